// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared check-mode encodings and helpers for the router register stage
package router_pkg;

    localparam int CHK_XOR = 0;
    localparam int CHK_SUM = 1;

    // The all-ones address is reserved and never latched as a destination.
    function automatic logic is_rsvd_addr(input logic [31:0] addr, input int aw);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < aw) r = r & addr[i];
        end
        return r;
    endfunction

    // One accumulation step of the packet integrity check; callers truncate to their width.
    function automatic logic [31:0] chk_op(input logic [31:0] a, input logic [31:0] b,
                                           input int mode);
        return (mode == CHK_SUM) ? (a + b) : (a ^ b);
    endfunction

endpackage

// File: rtl/router_hold_fifo.sv
// rtl/router_hold_fifo.sv - small FIFO holding words that arrive while the destination is full
module router_hold_fifo #(
    parameter int DW         = 8,
    parameter int HOLD_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int AW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] mem_d [2**AW];
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // The extra pointer MSB lets the difference reach HOLD_DEPTH, separating full from empty.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(HOLD_DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer and storage update; clear only rewinds pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = din;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/router_pkt_register_v2.sv
// rtl/router_pkt_register_v2.sv - router input register stage with hold buffer and packet checks
module router_pkt_register_v2
    import router_pkg::*;
#(
    parameter int DW         = 8,
    parameter int ADDR_W     = 2,
    parameter int HOLD_DEPTH = 4,
    parameter int CHK_MODE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_vld,
    input  logic              fifo_full,
    input  logic              rst_int_reg,
    input  logic              detect_addr,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic [DW-1:0]     d_in,
    output logic [DW-1:0]     d_out,
    output logic              d_out_vld,
    output logic [ADDR_W-1:0] hdr_addr,
    output logic              hold_empty,
    output logic              parity_done,
    output logic              low_pkt_vld,
    output logic              err,
    output logic              len_err,
    output logic              ovf_err
);

    localparam int LW = DW - ADDR_W;

    logic [DW-1:0]     hdr_q, hdr_d;
    logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
    logic [LW-1:0]     len_exp_q, len_exp_d;
    logic [DW-1:0]     d_out_q, d_out_d;
    logic              d_out_vld_q, d_out_vld_d;
    logic [DW-1:0]     int_chk_q, int_chk_d;
    logic [DW-1:0]     pkt_chk_q, pkt_chk_d;
    logic [LW-1:0]     pay_cnt_q, pay_cnt_d;
    logic              low_pkt_vld_q, low_pkt_vld_d;
    logic              parity_done_q, parity_done_d;
    logic              pd_seen_q, pd_seen_d;
    logic              err_q, err_d;
    logic              len_err_q, len_err_d;
    logic              ovf_err_q, ovf_err_d;
    logic              end_seen_q, end_seen_d;

    logic          hold_push, hold_pop, hold_full;
    logic [DW-1:0] hold_dout;
    logic          ld_word, ld_fwd, ld_push, laf_pop, chk_in, pkt_end, rsvd;

    assign rsvd      = is_rsvd_addr(32'(d_in[ADDR_W-1:0]), ADDR_W);
    assign ld_word   = ld_state & pkt_vld;
    assign ld_fwd    = ld_word & ~fifo_full;
    assign ld_push   = ld_word & fifo_full;
    assign laf_pop   = laf_state & ~fifo_full & ~hold_empty;
    assign chk_in    = ld_word & ~full_state;
    assign pkt_end   = ld_state & ~pkt_vld & ~end_seen_q;
    assign hold_push = ~lfd_state & ld_push;
    assign hold_pop  = ~lfd_state & ~ld_word & laf_pop;

    router_hold_fifo #(
        .DW         (DW),
        .HOLD_DEPTH (HOLD_DEPTH)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .clear (detect_addr),
        .push  (hold_push),
        .pop   (hold_pop),
        .din   (d_in),
        .dout  (hold_dout),
        .empty (hold_empty),
        .full  (hold_full)
    );

    // Header capture, output word selection, check accumulation and error evaluation.
    always_comb begin
        hdr_d         = hdr_q;
        hdr_addr_d    = hdr_addr_q;
        len_exp_d     = len_exp_q;
        d_out_d       = d_out_q;
        d_out_vld_d   = 1'b0;
        int_chk_d     = int_chk_q;
        pkt_chk_d     = pkt_chk_q;
        pay_cnt_d     = pay_cnt_q;
        low_pkt_vld_d = low_pkt_vld_q;
        parity_done_d = parity_done_q;
        pd_seen_d     = parity_done_q;
        err_d         = err_q;
        len_err_d     = len_err_q;
        ovf_err_d     = ovf_err_q;
        end_seen_d    = end_seen_q;

        if (detect_addr) begin
            int_chk_d     = '0;
            pkt_chk_d     = '0;
            pay_cnt_d     = '0;
            parity_done_d = 1'b0;
            err_d         = 1'b0;
            len_err_d     = 1'b0;
            ovf_err_d     = 1'b0;
            end_seen_d    = 1'b0;
            if (pkt_vld && !rsvd) begin
                hdr_d      = d_in;
                hdr_addr_d = d_in[ADDR_W-1:0];
                len_exp_d  = d_in[DW-1:ADDR_W];
            end
        end

        if (lfd_state) begin
            d_out_d     = hdr_q;
            d_out_vld_d = 1'b1;
        end else if (ld_fwd) begin
            d_out_d     = d_in;
            d_out_vld_d = 1'b1;
        end else if (ld_push) begin
            d_out_vld_d = 1'b0;
        end else if (laf_pop) begin
            d_out_d     = hold_dout;
            d_out_vld_d = 1'b1;
        end

        if (hold_push && hold_full) ovf_err_d = 1'b1;

        if (lfd_state) begin
            int_chk_d = DW'(chk_op(32'(int_chk_q), 32'(hdr_q), CHK_MODE));
        end else if (chk_in) begin
            int_chk_d = DW'(chk_op(32'(int_chk_q), 32'(d_in), CHK_MODE));
        end

        if (chk_in && (pay_cnt_q != '1)) pay_cnt_d = pay_cnt_q + LW'(1);

        if (pkt_end) begin
            pkt_chk_d  = d_in;
            end_seen_d = 1'b1;
        end

        if (rst_int_reg)  low_pkt_vld_d = 1'b0;
        else if (pkt_end) low_pkt_vld_d = 1'b1;

        if ((ld_state && !pkt_vld && !fifo_full) ||
            (laf_state && low_pkt_vld_q && !parity_done_q && hold_empty)) begin
            parity_done_d = 1'b1;
        end

        // Evaluated once, on the cycle after parity_done rises.
        if (parity_done_q && !pd_seen_q && !detect_addr) begin
            err_d     = (int_chk_q != pkt_chk_q);
            len_err_d = (pay_cnt_q != len_exp_q);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q         <= '0;
            hdr_addr_q    <= '0;
            len_exp_q     <= '0;
            d_out_q       <= '0;
            d_out_vld_q   <= 1'b0;
            int_chk_q     <= '0;
            pkt_chk_q     <= '0;
            pay_cnt_q     <= '0;
            low_pkt_vld_q <= 1'b0;
            parity_done_q <= 1'b0;
            pd_seen_q     <= 1'b0;
            err_q         <= 1'b0;
            len_err_q     <= 1'b0;
            ovf_err_q     <= 1'b0;
            end_seen_q    <= 1'b0;
        end else begin
            hdr_q         <= hdr_d;
            hdr_addr_q    <= hdr_addr_d;
            len_exp_q     <= len_exp_d;
            d_out_q       <= d_out_d;
            d_out_vld_q   <= d_out_vld_d;
            int_chk_q     <= int_chk_d;
            pkt_chk_q     <= pkt_chk_d;
            pay_cnt_q     <= pay_cnt_d;
            low_pkt_vld_q <= low_pkt_vld_d;
            parity_done_q <= parity_done_d;
            pd_seen_q     <= pd_seen_d;
            err_q         <= err_d;
            len_err_q     <= len_err_d;
            ovf_err_q     <= ovf_err_d;
            end_seen_q    <= end_seen_d;
        end
    end

    assign d_out       = d_out_q;
    assign d_out_vld   = d_out_vld_q;
    assign hdr_addr    = hdr_addr_q;
    assign parity_done = parity_done_q;
    assign low_pkt_vld = low_pkt_vld_q;
    assign err         = err_q;
    assign len_err     = len_err_q;
    assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_router_pkt_register_v2.sv
// tb/tb_router_pkt_register_v2.sv - directed bench over xor/depth4, xor/depth2 and sum/depth4 instances
module tb_router_pkt_register_v2;

    logic       clk = 1'b0;
    logic       rst, pkt_vld, fifo_full, rst_int_reg, detect_addr;
    logic       lfd_state, ld_state, laf_state, full_state;
    logic [7:0] d_in;

    logic [7:0] d_out [3];
    logic       d_out_vld [3];
    logic [1:0] hdr_addr [3];
    logic       hold_empty [3];
    logic       parity_done [3];
    logic       low_pkt_vld [3];
    logic       err [3];
    logic       len_err [3];
    logic       ovf_err [3];

    int checks = 0;
    int errors = 0;

    localparam int X4 = 0;
    localparam int X2 = 1;
    localparam int S4 = 2;

    always #5 clk = ~clk;

    router_pkt_register_v2 #(.DW(8), .ADDR_W(2), .HOLD_DEPTH(4), .CHK_MODE(0)) u_x4 (
        .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_addr(detect_addr), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state), .d_in(d_in),
        .d_out(d_out[0]), .d_out_vld(d_out_vld[0]), .hdr_addr(hdr_addr[0]),
        .hold_empty(hold_empty[0]), .parity_done(parity_done[0]), .low_pkt_vld(low_pkt_vld[0]),
        .err(err[0]), .len_err(len_err[0]), .ovf_err(ovf_err[0]));

    router_pkt_register_v2 #(.DW(8), .ADDR_W(2), .HOLD_DEPTH(2), .CHK_MODE(0)) u_x2 (
        .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_addr(detect_addr), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state), .d_in(d_in),
        .d_out(d_out[1]), .d_out_vld(d_out_vld[1]), .hdr_addr(hdr_addr[1]),
        .hold_empty(hold_empty[1]), .parity_done(parity_done[1]), .low_pkt_vld(low_pkt_vld[1]),
        .err(err[1]), .len_err(len_err[1]), .ovf_err(ovf_err[1]));

    router_pkt_register_v2 #(.DW(8), .ADDR_W(2), .HOLD_DEPTH(4), .CHK_MODE(1)) u_s4 (
        .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_addr(detect_addr), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state), .d_in(d_in),
        .d_out(d_out[2]), .d_out_vld(d_out_vld[2]), .hdr_addr(hdr_addr[2]),
        .hold_empty(hold_empty[2]), .parity_done(parity_done[2]), .low_pkt_vld(low_pkt_vld[2]),
        .err(err[2]), .len_err(len_err[2]), .ovf_err(ovf_err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        rst = 1'b0; pkt_vld = 1'b0; fifo_full = 1'b0; rst_int_reg = 1'b0;
        detect_addr = 1'b0; lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0;
        full_state = 1'b0; d_in = 8'h00;
    endtask

    // Advance one edge and leave outputs of that edge visible; inputs then return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    task automatic do_detect(input logic [7:0] hdr);
        detect_addr = 1'b1; pkt_vld = 1'b1; d_in = hdr; tick();
    endtask

    task automatic do_lfd();
        lfd_state = 1'b1; tick();
    endtask

    task automatic do_word(input logic [7:0] w, input logic full);
        ld_state = 1'b1; pkt_vld = 1'b1; d_in = w; fifo_full = full; tick();
    endtask

    task automatic do_end(input logic [7:0] c, input logic full);
        ld_state = 1'b1; pkt_vld = 1'b0; d_in = c; fifo_full = full; tick();
    endtask

    task automatic do_laf();
        laf_state = 1'b1; tick();
    endtask

    task automatic do_rst_int();
        rst_int_reg = 1'b1; tick();
    endtask

    // Unstalled packet on u_x4, checking the forwarded word stream.
    task automatic run_pkt(input string tag, input logic [7:0] hdr, input logic [7:0] w0,
                           input logic [7:0] w1, input logic [7:0] w2, input int n,
                           input logic [7:0] c);
        logic [7:0] w [3];
        w[0] = w0; w[1] = w1; w[2] = w2;
        do_detect(hdr);
        do_lfd();
        check({tag, "_hdr_dout"}, {d_out_vld[X4], d_out[X4]}, {1'b1, hdr});
        for (int i = 0; i < n; i++) begin
            do_word(w[i], 1'b0);
            check({tag, "_pay_dout"}, {d_out_vld[X4], d_out[X4]}, {1'b1, w[i]});
        end
        do_end(c, 1'b0);
        check({tag, "_end_pd_low_vld"}, {parity_done[X4], low_pkt_vld[X4], d_out_vld[X4]}, 3'b110);
        tick();
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_outs", {d_out[k], d_out_vld[k], hdr_addr[k], parity_done[k],
                               low_pkt_vld[k], err[k], len_err[k], ovf_err[k]}, 0);
            check("rst_hold_empty", hold_empty[k], 1);
        end
        clr_in();

        // Good xor packet: header 0D ^ 11 ^ 22 ^ 33 = 0D.
        run_pkt("good", 8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h0D);
        check("good_hdr_addr", hdr_addr[X4], 2'd1);
        check("good_err_len", {err[X4], len_err[X4]}, 2'b00);
        do_rst_int();
        check("rst_int_low", low_pkt_vld[X4], 0);

        // Wrong check byte, then a reserved-address detect clears err but keeps hdr_addr.
        run_pkt("bad", 8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h00);
        check("bad_err", err[X4], 1);
        check("bad_len_err", len_err[X4], 0);
        do_rst_int();
        do_detect(8'h0F);
        check("rsvd_err_clr", {err[X4], parity_done[X4]}, 2'b00);
        check("rsvd_hdr_addr", hdr_addr[X4], 2'd1);

        // Stall on 22/33, drain in LAF.
        do_detect(8'h0D);
        do_lfd();
        do_word(8'h11, 1'b0);
        do_word(8'h22, 1'b1);
        check("stall_hold", {d_out_vld[X4], d_out[X4], hold_empty[X4]}, {1'b0, 8'h11, 1'b0});
        do_word(8'h33, 1'b1);
        do_end(8'h0D, 1'b1);
        check("stall_end", {parity_done[X4], low_pkt_vld[X4]}, 2'b01);
        do_laf();
        check("drain0", {d_out_vld[X4], d_out[X4], hold_empty[X4]}, {1'b1, 8'h22, 1'b0});
        do_laf();
        check("drain1", {d_out_vld[X4], d_out[X4], hold_empty[X4]}, {1'b1, 8'h33, 1'b1});
        do_laf();
        check("drain_pd", parity_done[X4], 1);
        tick();
        check("stall_errs", {err[X4], len_err[X4], ovf_err[X4]}, 3'b000);
        do_rst_int();

        // Three words while full: depth-2 instance drops the third.
        do_detect(8'h0D);
        do_lfd();
        do_word(8'h11, 1'b1);
        do_word(8'h22, 1'b1);
        check("ovf_not_yet", ovf_err[X2], 0);
        do_word(8'h33, 1'b1);
        check("ovf_x2", ovf_err[X2], 1);
        check("ovf_x4", ovf_err[X4], 0);
        do_end(8'h0D, 1'b1);
        do_laf();
        check("ovf_drain0", {d_out_vld[X2], d_out[X2]}, {1'b1, 8'h11});
        do_laf();
        check("ovf_drain1", {d_out_vld[X2], d_out[X2], hold_empty[X2]}, {1'b1, 8'h22, 1'b1});
        do_laf();
        check("ovf_drain_end", {d_out_vld[X2], d_out[X2], parity_done[X2]}, {1'b0, 8'h22, 1'b1});
        check("ovf_x4_third", {d_out_vld[X4], d_out[X4]}, {1'b1, 8'h33});
        tick();
        check("ovf_sticky", ovf_err[X2], 1);
        do_rst_int();

        // Header length 4, three payload words: check 11^11^22^33 = 11.
        run_pkt("len", 8'h11, 8'h11, 8'h22, 8'h33, 3, 8'h11);
        check("len_err", {err[X4], len_err[X4]}, 2'b01);
        do_rst_int();

        // Sum mode: 05+FF+02 = 106 -> 06; xor instance sees F8 != 06; length 1 vs 2 words.
        run_pkt("sum", 8'h05, 8'hFF, 8'h02, 8'h00, 2, 8'h06);
        check("sum_err", {err[S4], len_err[S4]}, 2'b01);
        check("sum_xor_err", err[X4], 1);

        // Reset mid-payload with held data and a pending low_pkt_vld.
        do_detect(8'h0E);
        check("rst_pre_addr", hdr_addr[X4], 2'd2);
        do_lfd();
        do_word(8'h11, 1'b0);
        do_word(8'h22, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst_outs", {d_out[X4], d_out_vld[X4], hdr_addr[X4], parity_done[X4],
                              low_pkt_vld[X4], err[X4], len_err[X4], ovf_err[X4]}, 0);
        check("midrst_hold_empty", hold_empty[X4], 1);
        run_pkt("fresh", 8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h0D);
        check("fresh_errs", {err[X4], len_err[X4], ovf_err[X4]}, 3'b000);
        do_rst_int();

        // Empty packet: length 0, check equals header.
        run_pkt("empty", 8'h01, 8'h00, 8'h00, 8'h00, 0, 8'h01);
        check("empty_errs", {err[X4], len_err[X4], err[S4], len_err[S4]}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
